// File: rtl/adxl345.sv
`timescale 1ns/1ps
// adxl345: SPI mode-3 master that configures an ADXL345, then streams X/Y/Z bursts.
// A free-running tick paces the reads; outputs change only after a complete frame.
module adxl345 #(
    parameter int SYS_CLK_FREQ = 25000,
    parameter int SPI_CLK_FREQ = 2000,
    parameter int UPDATE_FREQ  = 10
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        freeze,
    output logic        data_update,
    output logic [15:0] data_x,
    output logic [15:0] data_y,
    output logic [15:0] data_z,
    output logic        interrupt,
    output logic        SPI_SDI,
    input  logic        SPI_SDO,
    output logic        SPI_CSN,
    output logic        SPI_CLK
);

    localparam int HALF = SYS_CLK_FREQ / (2 * SPI_CLK_FREQ);
    localparam int TICK = SYS_CLK_FREQ / UPDATE_FREQ;
    localparam int HW   = $clog2(2 * HALF + 1);
    localparam int TW   = $clog2(TICK);

    localparam logic [HW-1:0] HALF_END = HW'(HALF - 1);
    localparam logic [HW-1:0] GAP_END  = HW'(2 * HALF - 1);
    localparam logic [TW-1:0] TICK_END = TW'(TICK - 1);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_WR_FMT,
        ST_WR_PWR,
        ST_WAIT,
        ST_READ,
        ST_UPD
    } state_t;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_SETUP,
        SPI_LOW,
        SPI_HIGH,
        SPI_GAP
    } spi_state_t;

    state_t     state;
    state_t     next_state;
    spi_state_t spi_state;

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          tick_pend;

    logic          spi_start;
    logic          spi_idle;
    logic          spi_done;
    logic [55:0]   tx_load;
    logic [5:0]    frame_bits;

    logic [HW-1:0] half_cnt;
    logic [5:0]    bit_cnt;
    logic [5:0]    bit_total;
    logic [55:0]   tx_sr;
    logic [47:0]   rx_sr;

    // Sample-rate timebase; it never stops, so read spacing is exactly TICK clocks.
    assign tick = (tick_cnt == TICK_END);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // A tick that lands while a frame is in flight is remembered until WAIT.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tick_pend <= 1'b0;
        end else if (tick && state != ST_PWRUP) begin
            tick_pend <= 1'b1;
        end else if (state == ST_WAIT) begin
            tick_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_PWRUP;
        end else begin
            state <= next_state;
        end
    end

    assign spi_idle = (spi_state == SPI_IDLE);

    // Transfer states request a frame whenever the engine is idle; spi_done
    // arrives while the engine is in its CSN-high gap, so only one frame starts.
    always_comb begin
        next_state = state;
        spi_start  = 1'b0;
        tx_load    = '0;
        frame_bits = 6'd16;
        case (state)
            ST_PWRUP: begin
                if (tick) next_state = ST_WR_FMT;
            end
            ST_WR_FMT: begin
                tx_load   = {8'h31, 8'h0B, 40'h0};
                spi_start = spi_idle;
                if (spi_done) next_state = ST_WR_PWR;
            end
            ST_WR_PWR: begin
                tx_load   = {8'h2D, 8'h08, 40'h0};
                spi_start = spi_idle;
                if (spi_done) next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (tick_pend) next_state = ST_READ;
            end
            ST_READ: begin
                tx_load    = {8'hF2, 48'h0};
                frame_bits = 6'd56;
                spi_start  = spi_idle;
                if (spi_done) next_state = ST_UPD;
            end
            ST_UPD: begin
                next_state = ST_WAIT;
            end
            default: begin
                next_state = ST_PWRUP;
            end
        endcase
    end

    // Mode-3 bit engine: SDI launched on SCLK fall, SDO captured on SCLK rise.
    // rx_sr keeps only the last 48 bits, which drops the command-byte slot.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            spi_state <= SPI_IDLE;
            SPI_CSN   <= 1'b1;
            SPI_CLK   <= 1'b1;
            SPI_SDI   <= 1'b0;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            bit_total <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            spi_done  <= 1'b0;
        end else begin
            spi_done <= 1'b0;
            case (spi_state)
                SPI_IDLE: begin
                    if (spi_start) begin
                        SPI_CSN   <= 1'b0;
                        tx_sr     <= tx_load;
                        bit_total <= frame_bits;
                        bit_cnt   <= '0;
                        half_cnt  <= '0;
                        spi_state <= SPI_SETUP;
                    end
                end
                SPI_SETUP: begin
                    if (half_cnt == HALF_END) begin
                        half_cnt  <= '0;
                        SPI_CLK   <= 1'b0;
                        SPI_SDI   <= tx_sr[55];
                        tx_sr     <= {tx_sr[54:0], 1'b0};
                        spi_state <= SPI_LOW;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                SPI_LOW: begin
                    if (half_cnt == HALF_END) begin
                        half_cnt  <= '0;
                        SPI_CLK   <= 1'b1;
                        rx_sr     <= {rx_sr[46:0], SPI_SDO};
                        bit_cnt   <= bit_cnt + 6'd1;
                        spi_state <= SPI_HIGH;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                SPI_HIGH: begin
                    if (half_cnt == HALF_END) begin
                        half_cnt <= '0;
                        if (bit_cnt == bit_total) begin
                            SPI_CSN   <= 1'b1;
                            SPI_SDI   <= 1'b0;
                            spi_done  <= 1'b1;
                            spi_state <= SPI_GAP;
                        end else begin
                            SPI_CLK   <= 1'b0;
                            SPI_SDI   <= tx_sr[55];
                            tx_sr     <= {tx_sr[54:0], 1'b0};
                            spi_state <= SPI_LOW;
                        end
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                SPI_GAP: begin
                    if (half_cnt == GAP_END) begin
                        half_cnt  <= '0;
                        spi_state <= SPI_IDLE;
                    end else begin
                        half_cnt <= half_cnt + HW'(1);
                    end
                end
                default: begin
                    spi_state <= SPI_IDLE;
                end
            endcase
        end
    end

    // Shadow bytes arrive X0,X1,Y0,Y1,Z0,Z1; each axis word is {high, low}.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_x      <= '0;
            data_y      <= '0;
            data_z      <= '0;
            data_update <= 1'b0;
            interrupt   <= 1'b0;
        end else begin
            data_update <= 1'b0;
            interrupt   <= 1'b0;
            if (state == ST_UPD && !freeze) begin
                data_x      <= {rx_sr[39:32], rx_sr[47:40]};
                data_y      <= {rx_sr[23:16], rx_sr[31:24]};
                data_z      <= {rx_sr[7:0],   rx_sr[15:8]};
                data_update <= 1'b1;
                interrupt   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adxl345.sv
`timescale 1ns/1ps
// tb_adxl345: ADXL345 sensor model plus checks of init frames, burst reads, freeze,
// update rate, mode-3 SPI timing and asynchronous reset.
module tb_adxl345;

    localparam int CLK_NS    = 40;
    localparam int HALF_NS   = 6 * CLK_NS;
    localparam int TICK_CLKS = 2500;

    logic        clk     = 1'b0;
    logic        n_rst   = 1'b0;
    logic        freeze  = 1'b0;
    logic        SPI_SDO = 1'b0;
    logic        data_update;
    logic [15:0] data_x;
    logic [15:0] data_y;
    logic [15:0] data_z;
    logic        interrupt;
    logic        SPI_SDI;
    logic        SPI_CSN;
    logic        SPI_CLK;

    adxl345 dut (
        .clk(clk),
        .n_rst(n_rst),
        .freeze(freeze),
        .data_update(data_update),
        .data_x(data_x),
        .data_y(data_y),
        .data_z(data_z),
        .interrupt(interrupt),
        .SPI_SDI(SPI_SDI),
        .SPI_SDO(SPI_SDO),
        .SPI_CSN(SPI_CSN),
        .SPI_CLK(SPI_CLK)
    );

    always #20 clk = ~clk;

    typedef struct packed {
        logic [47:0] sdo;
        logic        frz;
        logic [15:0] ex;
        logic [15:0] ey;
        logic [15:0] ez;
        logic        pulse;
    } vec_t;

    vec_t tbl [6];

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] sdo_next = '0;
    logic [47:0] sdo_cur  = '0;
    logic [63:0] frame_sr = '0;
    logic [55:0] last_read_mosi = '0;
    logic [15:0] write_q [$];
    int  bit_cnt     = 0;
    int  fall_idx    = 0;
    int  read_frames = 0;
    int  timing_err  = 0;
    int  sdi_err     = 0;
    int  mirror_err  = 0;
    int  last_period = 0;
    int  pulse_cnt   = 0;
    int  irq_cnt     = 0;
    time t_csn_fall   = 0;
    time t_csn_rise   = 0;
    time t_last_fall  = 0;
    time t_last_rise  = 0;
    time t_sdi        = 0;
    time last_pulse_t = 0;
    time prev_pulse_t = 0;

    // Sensor model: a new frame latches the bytes it will return.
    always @(negedge SPI_CSN) begin
        if (n_rst && ($time - t_csn_rise) < 2 * HALF_NS) timing_err++;
        t_csn_fall = $time;
        bit_cnt    = 0;
        fall_idx   = 0;
        frame_sr   = '0;
        sdo_cur    = sdo_next;
        SPI_SDO    = 1'($urandom);
    end

    always @(negedge SPI_CLK) begin
        if (!SPI_CSN && n_rst) begin
            if (fall_idx == 0) begin
                if ($time - t_csn_fall != HALF_NS) timing_err++;
            end else begin
                last_period = int'($time - t_last_fall);
                if (last_period != 2 * HALF_NS) timing_err++;
            end
            t_last_fall = $time;
            if (fall_idx < 8) SPI_SDO = 1'($urandom);
            else if (fall_idx < 56) SPI_SDO = sdo_cur[55 - fall_idx];
            else SPI_SDO = 1'b0;
            fall_idx++;
        end
    end

    always @(SPI_SDI) t_sdi = $time;

    always @(posedge SPI_CLK) begin
        if (!SPI_CSN && n_rst) begin
            if ($time - t_sdi < HALF_NS - CLK_NS) sdi_err++;
            frame_sr    = {frame_sr[62:0], SPI_SDI};
            bit_cnt++;
            t_last_rise = $time;
        end
    end

    always @(posedge SPI_CSN) begin
        if (n_rst) begin
            if ($time - t_last_rise != HALF_NS) timing_err++;
            if (bit_cnt == 16) begin
                write_q.push_back(frame_sr[15:0]);
            end else if (bit_cnt == 56) begin
                last_read_mosi = frame_sr[55:0];
                read_frames++;
            end else begin
                timing_err++;
            end
        end
        t_csn_rise = $time;
    end

    always @(negedge clk) begin
        if (data_update === 1'b1) begin
            pulse_cnt++;
            prev_pulse_t = last_pulse_t;
            last_pulse_t = $time;
        end
        if (interrupt === 1'b1) irq_cnt++;
        if (interrupt !== data_update) mirror_err++;
        if (n_rst && SPI_CSN && !SPI_CLK) timing_err++;
    end

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [47:0] sdo, input logic frz);
        sdo_next = sdo;
        freeze   = frz;
    endtask

    task automatic waitRead(output bit ok);
        int r0;
        int n;
        r0 = read_frames;
        n  = 0;
        while (read_frames == r0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        ok = (read_frames != r0);
        checkVal("read_frame_seen", 64'(ok), 64'd1);
    endtask

    task automatic waitWrites(input string name);
        int n;
        n = 0;
        while (write_q.size() < 2 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checkVal({name, "_frame_count"}, 64'(write_q.size()), 64'd2);
        if (write_q.size() >= 2) begin
            checkVal({name, "_data_format"}, 64'(write_q[0]), 64'h310B);
            checkVal({name, "_power_ctl"},   64'(write_q[1]), 64'h2D08);
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] ex, input logic [15:0] ey,
                               input logic [15:0] ez, input logic pulse, input logic check_rate);
        int p0;
        int i0;
        bit ok;
        p0 = pulse_cnt;
        i0 = irq_cnt;
        waitRead(ok);
        if (!ok) return;
        repeat (8) @(negedge clk);
        checkVal({name, "_mosi"},   64'(last_read_mosi), {8'h0, 8'hF2, 48'h0});
        checkVal({name, "_pulses"}, 64'(pulse_cnt - p0), pulse ? 64'd1 : 64'd0);
        checkVal({name, "_irqs"},   64'(irq_cnt - i0),   pulse ? 64'd1 : 64'd0);
        checkVal({name, "_x"}, 64'(data_x), 64'(ex));
        checkVal({name, "_y"}, 64'(data_y), 64'(ey));
        checkVal({name, "_z"}, 64'(data_z), 64'(ez));
        if (check_rate)
            checkVal({name, "_spacing_ns"}, 64'(last_pulse_t - prev_pulse_t), 64'(TICK_CLKS * CLK_NS));
    endtask

    initial begin
        logic [7:0]  rb [6];
        logic [47:0] sdo;
        logic        frz;
        logic        prev_pulsed;
        logic [15:0] mx;
        logic [15:0] my;
        logic [15:0] mz;
        int          n;

        tbl[0] = '{48'h3412CDAB0180, 1'b0, 16'h1234, 16'hABCD, 16'h8001, 1'b1};
        tbl[1] = '{48'h785600FF7F00, 1'b0, 16'h5678, 16'hFF00, 16'h007F, 1'b1};
        tbl[2] = '{48'hAABBCCDDEEFF, 1'b1, 16'h5678, 16'hFF00, 16'h007F, 1'b0};
        tbl[3] = '{48'h112233445566, 1'b1, 16'h5678, 16'hFF00, 16'h007F, 1'b0};
        tbl[4] = '{48'h0000FFFF0080, 1'b0, 16'h0000, 16'hFFFF, 16'h8000, 1'b1};
        tbl[5] = '{48'hFF7F0080FEFF, 1'b0, 16'h7FFF, 16'h8000, 16'hFFFE, 1'b1};

        #100;
        checkVal("rst_csn",    64'(SPI_CSN),     64'd1);
        checkVal("rst_sclk",   64'(SPI_CLK),     64'd1);
        checkVal("rst_sdi",    64'(SPI_SDI),     64'd0);
        checkVal("rst_x",      64'(data_x),      64'd0);
        checkVal("rst_y",      64'(data_y),      64'd0);
        checkVal("rst_z",      64'(data_z),      64'd0);
        checkVal("rst_update", 64'(data_update), 64'd0);
        checkVal("rst_irq",    64'(interrupt),   64'd0);
        @(negedge clk);
        n_rst = 1'b1;

        waitWrites("init");
        checkVal("sclk_period_ns", 64'(last_period), 64'(2 * HALF_NS));

        prev_pulsed = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(tbl[i].sdo, tbl[i].frz);
            checkOutput($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ez,
                        tbl[i].pulse, tbl[i].pulse && prev_pulsed);
            prev_pulsed = tbl[i].pulse;
        end

        mx = tbl[5].ex;
        my = tbl[5].ey;
        mz = tbl[5].ez;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 6; k++) rb[k] = 8'($urandom);
            sdo = {rb[0], rb[1], rb[2], rb[3], rb[4], rb[5]};
            frz = ($urandom_range(0, 3) == 0);
            if (!frz) begin
                mx = {rb[1], rb[0]};
                my = {rb[3], rb[2]};
                mz = {rb[5], rb[4]};
            end
            applyStimulus(sdo, frz);
            checkOutput($sformatf("rnd%0d", i), mx, my, mz, !frz, !frz && prev_pulsed);
            prev_pulsed = !frz;
        end

        freeze = 1'b0;
        n = 0;
        while (SPI_CSN !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkVal("midrun_csn_low", 64'(SPI_CSN), 64'd0);
        repeat (100) @(negedge clk);
        #5 n_rst = 1'b0;
        #5;
        checkVal("midrun_rst_csn",    64'(SPI_CSN),     64'd1);
        checkVal("midrun_rst_sclk",   64'(SPI_CLK),     64'd1);
        checkVal("midrun_rst_x",      64'(data_x),      64'd0);
        checkVal("midrun_rst_y",      64'(data_y),      64'd0);
        checkVal("midrun_rst_z",      64'(data_z),      64'd0);
        checkVal("midrun_rst_update", 64'(data_update), 64'd0);
        #20 n_rst = 1'b1;
        write_q.delete();

        waitWrites("reinit");
        checkVal("reinit_x_still_zero", 64'(data_x), 64'd0);
        for (int k = 0; k < 6; k++) rb[k] = 8'($urandom);
        applyStimulus({rb[0], rb[1], rb[2], rb[3], rb[4], rb[5]}, 1'b0);
        checkOutput("post_reset", {rb[1], rb[0]}, {rb[3], rb[2]}, {rb[5], rb[4]}, 1'b1, 1'b0);

        checkVal("spi_timing_errors",    64'(timing_err), 64'd0);
        checkVal("sdi_stability_errors", 64'(sdi_err),    64'd0);
        checkVal("irq_mirror_errors",    64'(mirror_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
